// File: rtl/mult_seq_arbiter.sv
// Two-requester round-robin front end for a shift-add WIDTH x WIDTH unsigned multiplier.
// Optional macro EARLY_TERM_EN ends RUN as soon as the remaining multiplier bits are zero.
module mult_seq_arbiter #(
   parameter int unsigned WIDTH = 8
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 req0_valid,
   output logic                 req0_ready,
   input  logic [WIDTH-1:0]     req0_a,
   input  logic [WIDTH-1:0]     req0_b,
   input  logic                 req1_valid,
   output logic                 req1_ready,
   input  logic [WIDTH-1:0]     req1_a,
   input  logic [WIDTH-1:0]     req1_b,
   output logic                 res_valid,
   input  logic                 res_ready,
   output logic [2*WIDTH-1:0]   res_data,
   output logic                 res_id
);

   localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t               state;
   logic                 ptr;
   logic                 id;
   logic [WIDTH-1:0]     a_reg;
   logic [2*WIDTH-1:0]   b_sh;
   logic [2*WIDTH-1:0]   acc;
   logic [CW-1:0]        cnt;

   logic                 grant0;
   logic                 grant1;
   logic [2*WIDTH-1:0]   acc_sum;
   logic [WIDTH-1:0]     a_next;
   logic                 run_last;

   // ptr holds the last served requester; the other one wins a tie
   always_comb begin
      grant0 = 1'b0;
      grant1 = 1'b0;
      if (state == IDLE) begin
         if (req0_valid && (!req1_valid || ptr))
            grant0 = 1'b1;
         else if (req1_valid)
            grant1 = 1'b1;
      end
   end

   assign req0_ready = grant0;
   assign req1_ready = grant1;

   always_comb begin
      acc_sum  = acc + (a_reg[0] ? b_sh : '0);
      a_next   = a_reg >> 1;
`ifdef EARLY_TERM_EN
      run_last = (cnt == CW'(WIDTH - 1)) || (a_next == '0);
`else
      run_last = (cnt == CW'(WIDTH - 1));
`endif
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state     <= IDLE;
         ptr       <= 1'b1;
         id        <= 1'b0;
         a_reg     <= '0;
         b_sh      <= '0;
         acc       <= '0;
         cnt       <= '0;
         res_valid <= 1'b0;
         res_data  <= '0;
         res_id    <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (grant0 || grant1) begin
                  a_reg <= grant1 ? req1_a : req0_a;
                  b_sh  <= {{WIDTH{1'b0}}, (grant1 ? req1_b : req0_b)};
                  acc   <= '0;
                  cnt   <= '0;
                  id    <= grant1;
                  state <= RUN;
               end
            end
            RUN: begin
               acc   <= acc_sum;
               a_reg <= a_next;
               b_sh  <= b_sh << 1;
               cnt   <= cnt + 1'b1;
               // result registers load with the final sum so they are valid on DONE entry
               if (run_last) begin
                  state     <= DONE;
                  res_valid <= 1'b1;
                  res_data  <= acc_sum;
                  res_id    <= id;
               end
            end
            DONE: begin
               if (res_ready) begin
                  ptr       <= id;
                  state     <= IDLE;
                  res_valid <= 1'b0;
                  res_data  <= '0;
                  res_id    <= 1'b0;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mult_seq_arbiter.sv
// Directed plus randomized checks of mult_seq_arbiter against a product/round-robin reference model.
module tb_mult_seq_arbiter;

   localparam int unsigned WIDTH = 8;

   logic                 clk = 1'b0;
   logic                 rst;
   logic                 req0_valid, req1_valid;
   logic                 req0_ready, req1_ready;
   logic [WIDTH-1:0]     req0_a, req0_b, req1_a, req1_b;
   logic                 res_valid, res_ready;
   logic [2*WIDTH-1:0]   res_data;
   logic                 res_id;

   int compared   = 0;
   int mismatched = 0;
   int last_id    = 1;

   always #5 clk = ~clk;

   mult_seq_arbiter #(.WIDTH(WIDTH)) dut (
      .clk        (clk),
      .rst        (rst),
      .req0_valid (req0_valid),
      .req0_ready (req0_ready),
      .req0_a     (req0_a),
      .req0_b     (req0_b),
      .req1_valid (req1_valid),
      .req1_ready (req1_ready),
      .req1_a     (req1_a),
      .req1_b     (req1_b),
      .res_valid  (res_valid),
      .res_ready  (res_ready),
      .res_data   (res_data),
      .res_id     (res_id)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      compared++;
      assert (obs === exp) else begin
         mismatched++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic int exp_latency(input logic [WIDTH-1:0] a);
      int k;
`ifdef EARLY_TERM_EN
      k = 1;
      for (int i = 0; i < int'(WIDTH); i++)
         if (a[i]) k = i + 1;
`else
      k = WIDTH;
`endif
      return k + 1;
   endfunction

   // One accept/result transaction; hold = extra DONE cycles with res_ready low.
   task automatic txn(input logic v0, input logic v1,
                      input logic [WIDTH-1:0] a0, input logic [WIDTH-1:0] b0,
                      input logic [WIDTH-1:0] a1, input logic [WIDTH-1:0] b1,
                      input int hold, input bit cont);
      int g;
      int lat;
      bit seen;
      logic [WIDTH-1:0] ga, gb;
      logic [2*WIDTH-1:0] prod;
      @(negedge clk);
      req0_valid = v0; req0_a = a0; req0_b = b0;
      req1_valid = v1; req1_a = a1; req1_b = b1;
      res_ready  = (hold == 0);
      #1;
      if (v0 && v1) g = (last_id == 0) ? 1 : 0;
      else          g = v1 ? 1 : 0;
      check("req0_ready_grant", req0_ready, (g == 0));
      check("req1_ready_grant", req1_ready, (g == 1));
      ga   = (g == 1) ? a1 : a0;
      gb   = (g == 1) ? b1 : b0;
      prod = ga * gb;
      lat  = 0;
      seen = 0;
      while (!seen && lat < 40) begin
         @(negedge clk);
         if (!cont) begin
            if (g == 0) req0_valid = 1'b0;
            else        req1_valid = 1'b0;
         end
         #1;
         lat++;
         if (res_valid) seen = 1;
         else begin
            check("run_req0_ready", req0_ready, 0);
            check("run_req1_ready", req1_ready, 0);
            check("run_res_data_zero", res_data, 0);
         end
      end
      check("res_valid_seen", seen, 1);
      check("latency", lat, exp_latency(ga));
      check("res_data", res_data, prod);
      check("res_id", res_id, g);
      for (int i = 1; i < hold; i++) begin
         @(negedge clk);
         #1;
         check("hold_res_valid", res_valid, 1);
         check("hold_res_data", res_data, prod);
         check("hold_res_id", res_id, g);
         check("hold_req0_ready", req0_ready, 0);
         check("hold_req1_ready", req1_ready, 0);
      end
      if (hold > 0) begin
         @(negedge clk);
         res_ready = 1'b1;
         #1;
         check("release_res_valid", res_valid, 1);
      end
      last_id = g;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [WIDTH-1:0] ra, rb, rc, rd;
      int pat;
      rst = 1'b0;
      req0_valid = 1'b0; req1_valid = 1'b0;
      req0_a = '0; req0_b = '0; req1_a = '0; req1_b = '0;
      res_ready = 1'b0;
      repeat (3) @(negedge clk);
      #1;
      check("rst_res_valid", res_valid, 0);
      check("rst_res_data", res_data, 0);
      check("rst_res_id", res_id, 0);
      check("rst_req0_ready", req0_ready, 0);
      check("rst_req1_ready", req1_ready, 0);
      @(negedge clk);
      rst = 1'b1;

      // full-scale operands
      txn(1, 0, 8'd255, 8'd255, 8'd0, 8'd0, 0, 0);
      // short multiplier, latency depends on build
      txn(1, 0, 8'd3, 8'd5, 8'd0, 8'd0, 1, 0);
      // zero multiplier
      txn(0, 1, 8'd0, 8'd0, 8'd0, 8'd77, 0, 0);

      // tie from reset pointer state: req0 first, req1 waits
      @(negedge clk);
      rst = 1'b0;
      req0_valid = 1'b0; req1_valid = 1'b0;
      repeat (2) @(negedge clk);
      rst = 1'b1;
      last_id = 1;
      txn(1, 1, 8'd12, 8'd10, 8'd7, 8'd9, 2, 0);
      txn(0, 1, 8'd12, 8'd10, 8'd7, 8'd9, 0, 0);

      // result stalled for 20 cycles
      txn(1, 0, 8'h80, 8'h02, 8'd0, 8'd0, 20, 0);

      // reset in the middle of RUN
      @(negedge clk);
      req0_valid = 1'b1; req0_a = 8'd200; req0_b = 8'd100;
      req1_valid = 1'b0; res_ready = 1'b1;
      #1;
      check("mid_accept_ready", req0_ready, 1);
      @(negedge clk);
      req0_valid = 1'b0;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      #1;
      check("abort_res_valid", res_valid, 0);
      check("abort_res_data", res_data, 0);
      check("abort_res_id", res_id, 0);
      repeat (2) @(negedge clk);
      rst = 1'b1;
      last_id = 1;
      for (int i = 0; i < 15; i++) begin
         @(negedge clk);
         #1;
         check("post_abort_res_valid", res_valid, 0);
         check("post_abort_res_data", res_data, 0);
         check("post_abort_res_id", res_id, 0);
         check("post_abort_req0_ready", req0_ready, 0);
         check("post_abort_req1_ready", req1_ready, 0);
      end
      txn(1, 0, 8'd2, 8'd3, 8'd0, 8'd0, 0, 0);

      // both requesters continuously valid: round-robin alternation
      for (int i = 0; i < 6; i++) begin
         ra = 8'($urandom); rb = 8'($urandom);
         rc = 8'($urandom); rd = 8'($urandom);
         txn(1, 1, ra, rb, rc, rd, 0, 1);
      end

      // randomized traffic
      for (int i = 0; i < 24; i++) begin
         pat = $urandom_range(1, 3);
         ra = 8'($urandom); rb = 8'($urandom);
         rc = 8'($urandom); rd = 8'($urandom);
         if ($urandom_range(0, 7) == 0) ra = '0;
         if ($urandom_range(0, 7) == 0) rc = 8'($urandom_range(0, 3));
         txn(pat[0], pat[1], ra, rb, rc, rd, $urandom_range(0, 3), 0);
      end

      @(negedge clk);
      req0_valid = 1'b0; req1_valid = 1'b0;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
